// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and default bit timing.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 434;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Prefixed so the receiver's own state names can share this package.
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick is high in the last cycle of every CLKS_PER_BIT-cycle period.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_CNT  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // tick is registered one count early so it lines up with the last cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (clear) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
            r_tick <= (r_cnt == PRE_CNT);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte intake, serialises start/data/parity/stop frames on tx.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t            r_state, w_state_nx;
    logic [DATA_BITS-1:0] r_shift, w_shift_nx;
    logic [IW-1:0]        r_bit, w_bit_nx;
    logic                 r_stop, w_stop_nx;
    logic                 r_tx, w_tx_nx;
    logic                 r_par, w_par_nx;
    logic                 w_tick, w_accept, w_last;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(w_accept),
        .tick (w_tick)
    );

    // Final cycle of the last stop bit doubles as an accept slot for back-to-back frames.
    assign w_last   = (r_state == TX_STOP) && (r_stop == LAST_STOP) && w_tick;
    assign tx_ready = (r_state == TX_IDLE) || w_last;
    assign w_accept = tx_valid && tx_ready;
    assign tx_busy  = (r_state != TX_IDLE);
    assign tx_done  = w_last;
    assign tx       = r_tx;

    always_comb begin
        w_state_nx = r_state;
        w_shift_nx = r_shift;
        w_bit_nx   = r_bit;
        w_stop_nx  = r_stop;
        w_tx_nx    = r_tx;
        w_par_nx   = r_par;
        case (r_state)
            TX_START: if (w_tick) begin
                w_state_nx = TX_DATA;
                w_tx_nx    = r_shift[0];
                w_shift_nx = r_shift >> 1;
                w_bit_nx   = '0;
            end
            TX_DATA: if (w_tick) begin
                if (r_bit == LAST_BIT) begin
                    if (PARITY != PARITY_NONE) begin
                        w_state_nx = TX_PARITY;
                        w_tx_nx    = r_par;
                    end else begin
                        w_state_nx = TX_STOP;
                        w_tx_nx    = 1'b1;
                        w_stop_nx  = 1'b0;
                    end
                end else begin
                    w_bit_nx   = r_bit + 1'b1;
                    w_tx_nx    = r_shift[0];
                    w_shift_nx = r_shift >> 1;
                end
            end
            TX_PARITY: if (w_tick) begin
                w_state_nx = TX_STOP;
                w_tx_nx    = 1'b1;
                w_stop_nx  = 1'b0;
            end
            TX_STOP: if (w_tick) begin
                if (r_stop == LAST_STOP) begin
                    w_state_nx = TX_IDLE;
                end else begin
                    w_stop_nx = r_stop + 1'b1;
                end
            end
            default: ;
        endcase
        // Accept overrides the stop-bit exit so the next start bit follows with no gap.
        if (w_accept) begin
            w_state_nx = TX_START;
            w_tx_nx    = 1'b0;
            w_shift_nx = tx_data[DATA_BITS-1:0];
            w_par_nx   = (^tx_data[DATA_BITS-1:0]) ^ (PARITY == PARITY_ODD);
            w_bit_nx   = '0;
            w_stop_nx  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= TX_IDLE;
            r_bit   <= '0;
            r_stop  <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nx;
            r_bit   <= w_bit_nx;
            r_stop  <= w_stop_nx;
            r_tx    <= w_tx_nx;
        end
    end

    always_ff @(posedge clk) begin
        r_shift <= w_shift_nx;
        r_par   <= w_par_nx;
    end

endmodule
